// File: rtl/stripe_rx_if.sv
// ============================================================================
//  Module   : stripe_rx_if
//  Brief    : Lane inputs and byte-stream outputs of the four-lane receiver.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface stripe_rx_if;
    logic       L0;
    logic       L1;
    logic       L2;
    logic       L3;
    logic       enb;
    logic [7:0] data_out;
    logic       valid;
    logic       locked;
    logic       sync_err;

    modport master (
        output L0, L1, L2, L3, enb,
        input  data_out, valid, locked, sync_err
    );

    modport slave (
        input  L0, L1, L2, L3, enb,
        output data_out, valid, locked, sync_err
    );
endinterface

`default_nettype wire

// File: rtl/stripe_rx.sv
// ============================================================================
//  Module   : stripe_rx
//  Brief    : Four-lane deserializer with COM alignment and byte un-striping.
//             Optional macro STRIPE_RX_COM_FILTER_EN drops all-COM groups.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module stripe_rx #(
    parameter logic [7:0] COM = 8'hBC
) (
    input wire logic    clk,
    input wire logic    reset,
    stripe_rx_if.slave  bus
);

    localparam logic [0:0] c_ST_SEARCH = 1'b0;
    localparam logic [0:0] c_ST_LOCKED = 1'b1;

    logic [3:0]       w_lane;
    logic [3:0][7:0]  w_nx;
    logic [3:0]       w_com;
    logic             w_all_com;
    logic             w_no_com;
    logic             w_emit_ok;

    logic [3:0][7:0]  r_sr;
    logic [3:1][7:0]  r_hold;
    logic [0:0]       r_state;
    logic [2:0]       r_cnt;
    logic [1:0]       r_idx;
    logic             r_busy;
    logic [7:0]       r_data;
    logic             r_valid;
    logic             r_locked;
    logic             r_sync_err;

    assign w_lane = {bus.L3, bus.L2, bus.L1, bus.L0};

    generate
        for (genvar n = 0; n < 4; n++) begin : g_lane
            assign w_nx[n]  = {r_sr[n][6:0], w_lane[n]};
            assign w_com[n] = (w_nx[n] == COM);
        end
    endgenerate

    assign w_all_com = &w_com;
    assign w_no_com  = ~|w_com;

`ifdef STRIPE_RX_COM_FILTER_EN
    assign w_emit_ok = ~w_all_com;
`else
    assign w_emit_ok = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sr       <= '0;
            r_hold     <= '0;
            r_state    <= c_ST_SEARCH;
            r_cnt      <= 3'd0;
            r_idx      <= 2'd0;
            r_busy     <= 1'b0;
            r_data     <= 8'h00;
            r_valid    <= 1'b0;
            r_locked   <= 1'b0;
            r_sync_err <= 1'b0;
        end else begin
            r_valid    <= 1'b0;
            r_sync_err <= 1'b0;
            if (bus.enb) begin
                r_sr <= w_nx;

                // Drain lanes 1..3 of the held group; never overlaps a group completion
                if (r_busy) begin
                    r_data  <= r_hold[r_idx];
                    r_valid <= 1'b1;
                    r_idx   <= r_idx + 2'd1;
                    if (r_idx == 2'd3) begin
                        r_busy <= 1'b0;
                    end
                end

                case (r_state)
                    c_ST_SEARCH: begin
                        r_cnt <= 3'd0;
                        if (w_all_com) begin
                            r_state  <= c_ST_LOCKED;
                            r_locked <= 1'b1;
                            if (w_emit_ok) begin
                                r_data  <= w_nx[0];
                                r_valid <= 1'b1;
                                r_hold  <= w_nx[3:1];
                                r_idx   <= 2'd1;
                                r_busy  <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        r_cnt <= r_cnt + 3'd1;
                        if (r_cnt == 3'd7) begin
                            if (w_all_com || w_no_com) begin
                                if (w_emit_ok) begin
                                    r_data  <= w_nx[0];
                                    r_valid <= 1'b1;
                                    r_hold  <= w_nx[3:1];
                                    r_idx   <= 2'd1;
                                    r_busy  <= 1'b1;
                                end
                            end else begin
                                r_sync_err <= 1'b1;
                                r_state    <= c_ST_SEARCH;
                                r_locked   <= 1'b0;
                                r_busy     <= 1'b0;
                                r_cnt      <= 3'd0;
                            end
                        end
                    end
                endcase
            end
        end
    end

    assign bus.data_out = r_data;
    assign bus.valid    = r_valid;
    assign bus.locked   = r_locked;
    assign bus.sync_err = r_sync_err;

endmodule

`default_nettype wire
